// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hack_pkg
// Purpose  : Shared definitions for the bit-serial adder: FSM state encoding,
//            default operand width and counter sizing helper.
// Revision : 1.0 - initial release
// ============================================================================
package hack_pkg;

    // Default operand/result width used by serial_adder when not overridden.
    localparam int c_DEFAULT_WIDTH = 16;

    // Controller state encoding.
    typedef logic [1:0] state_t;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Bit counter width: one bit of headroom above what is needed to index
    // the operand so the counter can be inspected without wrap ambiguity.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hFullAdder.sv
`default_nettype none
// ============================================================================
// Module   : hFullAdder
// Purpose  : One-bit full-adder cell (combinational).
// Ports    : i_a, i_b  - operand bits
//            i_cin     - carry in
//            o_sum     - sum bit
//            o_cout    - carry out
// Revision : 1.0 - initial release
// ============================================================================
module hFullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_half;

    assign w_half = i_a ^ i_b;
    assign o_sum  = w_half ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & w_half);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial adder. Operands are captured on an accepted start,
//            then one bit pair per clock (LSB first) passes through a single
//            full-adder cell. The finished result is published when the FSM
//            enters DONE, which also raises a one-cycle done pulse.
// Params   : WIDTH     - operand/result width in bits (2..32)
// Ports    : clk       - rising-edge clock
//            reset     - synchronous active-high reset
//            sub       - (SERIAL_ADDER_SUB_EN only) 1: a - b, 0: a + b + carry_in
//            start     - begin an addition (accepted in IDLE only)
//            a, b      - operands, sampled in the start-accept cycle
//            carry_in  - initial carry, sampled in the start-accept cycle
//            busy      - high while in RUN
//            done      - one-cycle pulse when the result becomes valid
//            out       - sum, held until the next result is published
//            carry_out - carry out of bit WIDTH-1
//            overflow  - signed overflow (carry into MSB xor carry out of MSB)
// Config   : define SERIAL_ADDER_SUB_EN to add the sub port and subtraction.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder
    import hack_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow
);

    localparam int c_CNT_W = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    // Holds the low WIDTH-1 sum bits; the final sum bit goes straight into
    // the published result, so no full-width shadow is needed.
    logic [WIDTH-2:0]   r_shift;
    logic [WIDTH-1:0]   r_out;
    logic               r_carry_out;
    logic               r_overflow;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               w_fa_sum;
    logic               w_fa_cout;
    logic               w_last;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_cin_load;
    logic [WIDTH-2:0]   w_shift_next;

    // Subtraction is a + ~b + 1, so the operand is inverted at capture time
    // and the initial carry is forced high; carry_in plays no part then.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load   = sub ? ~b : b;
    assign w_cin_load = sub ? 1'b1 : carry_in;
`else
    assign w_b_load   = b;
    assign w_cin_load = carry_in;
`endif

    assign w_last = (r_cnt == c_LAST_BIT);

    // Sum bits enter from the MSB side so that after WIDTH-1 shifts the
    // earliest (LSB) sum bit has settled at bit 0.
    generate
        if (WIDTH == 2) begin : g_shift_one
            assign w_shift_next = w_fa_sum;
        end else begin : g_shift_wide
            assign w_shift_next = {w_fa_sum, r_shift[WIDTH-2:1]};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Single full-adder cell shared across all bit positions
    // ------------------------------------------------------------------------
    hFullAdder u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // ------------------------------------------------------------------------
    // Controller and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_shift     <= '0;
            r_out       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_load;
                        r_carry <= w_cin_load;
                        r_cnt   <= '0;
                        r_shift <= '0;
                        r_state <= c_ST_RUN;
                    end
                end

                c_ST_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_fa_cout;
                    r_cnt   <= r_cnt + c_CNT_ONE;
                    if (w_last) begin
                        // MSB cycle: r_carry is the carry into the MSB and
                        // w_fa_cout the carry out of it.
                        r_out       <= {w_fa_sum, r_shift};
                        r_carry_out <= w_fa_cout;
                        r_overflow  <= r_carry ^ w_fa_cout;
                        r_state     <= c_ST_DONE;
                    end else begin
                        r_shift <= w_shift_next;
                    end
                end

                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy      = (r_state == c_ST_RUN);
    assign done      = (r_state == c_ST_DONE);
    assign out       = r_out;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Self-checking bench for serial_adder (WIDTH = 16). Table-driven
//            vectors plus directed sequences for ignored start, mid-run
//            reset and reset/start priority. Define SERIAL_ADDER_SUB_EN to
//            also exercise subtraction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int c_W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           carry_in;
    logic           busy;
    logic           done;
    logic [c_W-1:0] out;
    logic           carry_out;
    logic           overflow;
`ifdef SERIAL_ADDER_SUB_EN
    logic           sub;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] e_out;
        logic        e_cout;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[8];

    serial_adder #(.WIDTH(c_W)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation and check timing, hold behaviour and result.
    task automatic run_vec(input vec_t v, input int idx);
        int          cyc;
        int          busy_n;
        logic [15:0] prev;
        logic        moved;
        @(negedge clk);
        prev     = out;
        a        = v.a;
        b        = v.b;
        carry_in = v.cin;
`ifdef SERIAL_ADDER_SUB_EN
        sub      = v.sub;
`endif
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        // Operands are don't-care after acceptance; scramble them.
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        carry_in = ~v.cin;
`ifdef SERIAL_ADDER_SUB_EN
        sub      = ~v.sub;
`endif
        cyc    = 1;
        busy_n = 0;
        moved  = 1'b0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_n++;
            if (out !== prev) moved = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("v%0d_done_cycle", idx), cyc, 17);
        chk($sformatf("v%0d_busy_cycles", idx), busy_n, 16);
        chk($sformatf("v%0d_out_held_in_run", idx), {31'd0, moved}, 0);
        chk($sformatf("v%0d_out", idx), {16'd0, out}, {16'd0, v.e_out});
        chk($sformatf("v%0d_carry_out", idx), {31'd0, carry_out}, {31'd0, v.e_cout});
        chk($sformatf("v%0d_overflow", idx), {31'd0, overflow}, {31'd0, v.e_ovf});
        @(negedge clk);
        chk($sformatf("v%0d_done_width", idx), {31'd0, done}, 0);
        chk($sformatf("v%0d_out_hold", idx), {16'd0, out}, {16'd0, v.e_out});
    endtask

    initial begin
        int          ndone;
        int          dcyc;
        logic [15:0] got;
        vec_t        tmp;

        //          a         b         cin   sub   out       cout  ovf
        vecs[0] = '{16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_out", {16'd0, out}, 0);
        chk("reset_carry_out", {31'd0, carry_out}, 0);
        chk("reset_overflow", {31'd0, overflow}, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // start re-pulsed during RUN must be ignored.
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; dcyc = 0; got = '0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) begin
                start = 1'b1;
                a     = 16'h1234;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                ndone++;
                got  = out;
                dcyc = c;
            end
            @(negedge clk);
        end
        chk("ignore_start_done_count", ndone, 1);
        chk("ignore_start_done_cycle", dcyc, 17);
        chk("ignore_start_out", {16'd0, got}, 32'h0002);
        chk("ignore_start_idle_after", {31'd0, busy}, 0);

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_busy_before_reset", {31'd0, busy}, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_out", {16'd0, out}, 0);
        chk("abort_carry_out", {31'd0, carry_out}, 0);
        chk("abort_overflow", {31'd0, overflow}, 0);
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        chk("abort_no_done", ndone, 0);
        tmp = '{16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0};
        run_vec(tmp, 100);

        // Reset wins over start in the same cycle.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; a = 16'h0005; b = 16'h0005;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("reset_over_start_busy", {31'd0, busy}, 0);
        @(negedge clk);
        chk("reset_over_start_idle", {31'd0, busy}, 0);

`ifdef SERIAL_ADDER_SUB_EN
        tmp = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        run_vec(tmp, 200);
        tmp = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        run_vec(tmp, 201);
        tmp = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        run_vec(tmp, 202);
        tmp = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        run_vec(tmp, 203);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request to begin an addition, sampled on clk.
REQ-005 The block SHALL have port a  input  WIDTH  first operand, captured when start is accepted.
REQ-006 The block SHALL have port b  input  WIDTH  second operand, captured when start is accepted.
REQ-007 The block SHALL have port carry_in  input  1  initial carry, captured when start is accepted.
REQ-008 The block SHALL have port busy  output  1  high while an addition is in progress (RUN state).
REQ-009 The block SHALL have port done  output  1  single-cycle pulse when the result becomes valid.
REQ-010 The block SHALL have port out  output  WIDTH  sum result, held until the next accepted start.
REQ-011 The block SHALL have port carry_out  output  1  carry out of bit WIDTH-1.
REQ-012 The block SHALL have port overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; reset enters IDLE.
REQ-014 Start SHALL be accepted only in IDLE; on acceptance, a, b and carry_in are latched, bit counter cleared, and state goes to RUN next cycle.
REQ-015 In RUN, each cycle one bit pair (LSB first) plus the carry register SHALL pass through one full-adder cell; the sum bit shifts into the result register from the MSB side and the carry register updates.
REQ-016 RUN SHALL last exactly WIDTH cycles; after the cycle processing bit WIDTH-1, state goes to DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle; out, carry_out and overflow SHALL be valid from that cycle on; state returns to IDLE next cycle.
REQ-018 Latency SHALL be WIDTH+1 cycles from the start-accept edge to the done pulse (WIDTH+2 edges until next start can be accepted).
REQ-019 start asserted in RUN or DONE SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-020 Operand inputs SHALL be don't-care except in the start-accept cycle.
REQ-021 out, carry_out and overflow SHALL NOT change during RUN from their previous values as seen externally (result is shadowed and published on entering DONE).
REQ-022 Wrap-around: sums exceeding 2^WIDTH-1 SHALL be truncated to WIDTH bits with carry_out=1.

Reset
REQ-023 Reset SHALL force state IDLE, busy=0, done=0, out=0, carry_out=0, overflow=0, and clear counter, carry and shift registers.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; no done pulse follows; reset has priority over start in the same cycle.

Configuration
REQ-025 With macro SERIAL_ADDER_SUB_EN defined, the block SHALL add input port sub (1 bit), latched with start; sub=1 computes a + ~b + 1 (carry_in ignored), sub=0 computes a + b + carry_in.
REQ-026 Without SERIAL_ADDER_SUB_EN, port sub SHALL NOT exist and the block always adds.

Structure
REQ-027 State encoding (IDLE/RUN/DONE) and the default word width constant (16) SHALL live in shared package hack_pkg.
REQ-028 The per-bit sum/carry logic SHALL be the existing full-adder cell instantiated once as sub-module hFullAdder; no other sub-modules.
REQ-029 The bit counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-030 Reset then a=0x0003, b=0x0005, carry_in=0, start 1 cycle -> busy for 16 cycles, done pulse at cycle 17, out=0x0008, carry_out=0, overflow=0.
REQ-031 a=0xFFFF, b=0x0001, carry_in=0 -> out=0x0000, carry_out=1, overflow=0.
REQ-032 a=0x7FFF, b=0x0000, carry_in=1 -> out=0x8000, carry_out=0, overflow=1.
REQ-033 start with a=1,b=1, re-pulse start with a=0x1234 at RUN cycle 5 -> ignored; out=0x0002, exactly one done pulse.
REQ-034 start a=0x00FF,b=0x0001, reset at RUN cycle 8 -> no done, all outputs 0; next start a=2,b=2 -> out=0x0004.
REQ-035 SERIAL_ADDER_SUB_EN build: a=0x0005, b=0x0007, sub=1 -> out=0xFFFE, carry_out=0, overflow=0.
